alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// alu_pipe -- single-issue ALU with a valid/ready request side and a
// valid/ready result side. All ops except MUL finish in one cycle; MUL
// runs an iterative shift-add multiplier for WIDTH cycles.
//
// Build option:
//   ALU_PIPE_MUL_EN  defined   -> multiplier and BUSY state compiled in
//                    undefined -> opcode 10 is reported as an illegal op
//
// The result registers and flags are held until the consumer takes them.
// in_ready is combinational so a held result can be replaced in the same
// cycle it is consumed (back-to-back throughput of one op per cycle).
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] port_a,
  input  logic [WIDTH-1:0] port_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] port_o,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  // Opcode map
  localparam logic [3:0] OP_SLL  = 4'd0;
  localparam logic [3:0] OP_SRL  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd11;

  // Controller states; BUSY exists only when the multiplier is built
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd2;
`ifdef ALU_PIPE_MUL_EN
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [3:0] OP_MUL = 4'd10;
  // Iteration count at which the product is complete
  localparam logic [SHW:0] MUL_LAST = (SHW+1)'(WIDTH);
`endif

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] res_nxt;
  logic             ovf_nxt;
  logic             ill_nxt;

  // Single-cycle datapath
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic             slt_bit;
  logic             sltu_bit;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_ill;

`ifdef ALU_PIPE_MUL_EN
  // Iterative multiplier state: full-width accumulator so the upper half
  // is available for the overflow flag.
  logic [2*WIDTH-1:0] mul_acc;
  logic [2*WIDTH-1:0] mul_mcand;
  logic [WIDTH-1:0]   mul_mplier;
  logic [SHW:0]       mul_cnt;
  logic               mul_start;
`endif

  // A new request may enter when nothing is held, or when the held result
  // leaves this same cycle; never while reset is asserted.
  assign in_ready = ~RST & ((state == IDLE) | ((state == HOLD) & out_ready));
  assign accept   = in_valid & in_ready;

  assign shamt    = port_b[SHW-1:0];
  assign add_res  = port_a + port_b;
  assign sub_res  = port_a - port_b;
  assign slt_bit  = $signed(port_a) < $signed(port_b);
  assign sltu_bit = port_a < port_b;

  // Combinational result and flags for every single-cycle opcode
  always_comb begin
    alu_res = {WIDTH{1'b0}};
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (alu_op)
      OP_SLL:  alu_res = port_a << shamt;
      OP_SRL:  alu_res = port_a >> shamt;
      OP_SRA:  alu_res = $signed(port_a) >>> shamt;
      OP_ADD: begin
        alu_res = add_res;
        // Same-sign operands producing a different-sign sum
        alu_ovf = (port_a[WIDTH-1] == port_b[WIDTH-1]) &&
                  (add_res[WIDTH-1] != port_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_res;
        // Opposite-sign operands where the difference flips from port_a
        alu_ovf = (port_a[WIDTH-1] != port_b[WIDTH-1]) &&
                  (sub_res[WIDTH-1] != port_a[WIDTH-1]);
      end
      OP_AND:  alu_res = port_a & port_b;
      OP_OR:   alu_res = port_a | port_b;
      OP_XOR:  alu_res = port_a ^ port_b;
      OP_NOR:  alu_res = ~(port_a | port_b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, sltu_bit};
      default: begin
        // Reserved opcodes (and MUL when the multiplier is not built);
        // with the multiplier present a MUL never loads this result.
        alu_res = {WIDTH{1'b0}};
        alu_ill = 1'b1;
      end
    endcase
  end

  // Next-state and result-load decisions for the controller
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    res_nxt   = alu_res;
    ovf_nxt   = alu_ovf;
    ill_nxt   = alu_ill;
`ifdef ALU_PIPE_MUL_EN
    mul_start = 1'b0;
`endif
    case (state)
      IDLE, HOLD: begin
        if (accept) begin
`ifdef ALU_PIPE_MUL_EN
          if (alu_op == OP_MUL) begin
            state_nxt = BUSY;
            mul_start = 1'b1;
          end else begin
            state_nxt = HOLD;
            load      = 1'b1;
          end
`else
          state_nxt = HOLD;
          load      = 1'b1;
`endif
        end else if ((state == HOLD) && out_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = state;
        end
      end
`ifdef ALU_PIPE_MUL_EN
      BUSY: begin
        if (mul_cnt == MUL_LAST) begin
          state_nxt = HOLD;
          load      = 1'b1;
          res_nxt   = mul_acc[WIDTH-1:0];
          ovf_nxt   = |mul_acc[2*WIDTH-1:WIDTH];
          ill_nxt   = 1'b0;
        end else begin
          state_nxt = BUSY;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Controller state and the registered valid flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == HOLD);
    end
  end

  // Result and flag registers; stable while a result is held
  always_ff @(posedge CLK) begin
    if (RST) begin
      port_o   <= {WIDTH{1'b0}};
      negative <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else if (load) begin
      port_o   <= res_nxt;
      negative <= res_nxt[WIDTH-1];
      zero     <= (res_nxt == {WIDTH{1'b0}});
      overflow <= ovf_nxt;
      illegal  <= ill_nxt;
    end else begin
      port_o   <= port_o;
      negative <= negative;
      zero     <= zero;
      overflow <= overflow;
      illegal  <= illegal;
    end
  end

`ifdef ALU_PIPE_MUL_EN
  // Shift-add multiplier: one multiplier bit consumed per BUSY cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      mul_acc    <= {(2*WIDTH){1'b0}};
      mul_mcand  <= {(2*WIDTH){1'b0}};
      mul_mplier <= {WIDTH{1'b0}};
      mul_cnt    <= {(SHW+1){1'b0}};
    end else if (mul_start) begin
      // Operands are captured here so later input changes cannot leak in
      mul_acc    <= {(2*WIDTH){1'b0}};
      mul_mcand  <= {{WIDTH{1'b0}}, port_a};
      mul_mplier <= port_b;
      mul_cnt    <= {(SHW+1){1'b0}};
    end else if ((state == BUSY) && (mul_cnt != MUL_LAST)) begin
      if (mul_mplier[0]) begin
        mul_acc <= mul_acc + mul_mcand;
      end else begin
        mul_acc <= mul_acc;
      end
      mul_mcand  <= {mul_mcand[2*WIDTH-2:0], 1'b0};
      mul_mplier <= {1'b0, mul_mplier[WIDTH-1:1]};
      mul_cnt    <= mul_cnt + {{SHW{1'b0}}, 1'b1};
    end else begin
      mul_acc    <= mul_acc;
      mul_mcand  <= mul_mcand;
      mul_mplier <= mul_mplier;
      mul_cnt    <= mul_cnt;
    end
  end
`endif

endmodule
